// File: rtl/tff_updown_counter.sv
// ---------------------------------------------------------------------------
// tff_updown_counter
//
// Synchronous up/down modulo counter built from T flip-flop stages. Every bit
// of q is a T stage: q[i] <= q[i] ^ t_vec[i]. The toggle vector is derived
// from the requested next count, so the T-stage form and the arithmetic
// next value always agree.
//
// Count range is 0..MODULUS-1. MODULUS need not be a power of two. When
// MODULUS equals 2**WIDTH the count toggles come from the classic
// prefix-AND ripple chain. Otherwise they come from q ^ q_next.
//
// Priority on each rising edge: rst > load > en.
//
// Parameters
//   WIDTH    counter width in bits (2..16)
//   MODULUS  number of count states (2..2**WIDTH)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (q=0, wrap=0)
//   en        count enable; q holds when 0
//   up        direction: 1 up, 0 down (only meaningful when en=1)
//   load      parallel load request (overrides en)
//   d         load value; values >= MODULUS saturate to MODULUS-1
//   clr_wrap  clears the sticky wrap flag
//   q         registered count
//   t_vec     combinational per-bit toggle vector (q ^ q_next)
//   tc        combinational terminal count: the coming edge wraps
//   wrap      registered sticky flag, set on any wrap-around
// ---------------------------------------------------------------------------
module tff_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
    localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

    // Terminal-count detection at WIDTH bits.
    logic at_top;
    logic at_bottom;

    assign at_top    = (q == MAX_VAL);
    assign at_bottom = (q == '0);

    // tc doubles as the wrap event: it is only true when the next edge
    // performs a count (not a load) that crosses the modulus boundary.
    assign tc = en & ~load & ((up & at_top) | (~up & at_bottom));

    // Load value with saturation to the top of the count range.
    logic [WIDTH-1:0] load_val;

    assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

    // Toggle vector for a counting edge (zero when en=0).
    logic [WIDTH-1:0] t_count;

    generate
        if (FULL_RANGE) begin : g_pow2
            // Full binary range: stage i toggles when all lower stages are 1
            // (up) or all are 0 (down). Wrap-around falls out naturally.
            logic [WIDTH-1:0] up_chain;
            logic [WIDTH-1:0] dn_chain;

            always_comb begin
                up_chain    = '0;
                dn_chain    = '0;
                up_chain[0] = 1'b1;
                dn_chain[0] = 1'b1;
                for (int i = 1; i < WIDTH; i++) begin
                    up_chain[i] = up_chain[i-1] & q[i-1];
                    dn_chain[i] = dn_chain[i-1] & ~q[i-1];
                end
            end

            assign t_count = en ? (up ? up_chain : dn_chain) : '0;
        end else begin : g_mod
            // Truncated range: compute the arithmetic next value one bit
            // wider so the compare against MODULUS and the borrow out of
            // zero are both visible, then convert to toggles.
            logic [WIDTH:0]   inc_w;
            logic [WIDTH:0]   dec_w;
            logic [WIDTH-1:0] count_next;

            assign inc_w = {1'b0, q} + (WIDTH+1)'(1);
            assign dec_w = {1'b0, q} - (WIDTH+1)'(1);

            always_comb begin
                count_next = q;
                if (up) begin
                    if (inc_w == (WIDTH+1)'(MODULUS)) begin
                        count_next = '0;
                    end else begin
                        count_next = inc_w[WIDTH-1:0];
                    end
                end else begin
                    // dec_w[WIDTH] is the borrow: q was zero.
                    if (dec_w[WIDTH]) begin
                        count_next = MAX_VAL;
                    end else begin
                        count_next = dec_w[WIDTH-1:0];
                    end
                end
            end

            assign t_count = en ? (q ^ count_next) : '0;
        end
    endgenerate

    // A load is also expressed as toggles so every edge goes through the
    // same T-stage update.
    assign t_vec = load ? (q ^ load_val) : t_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q <= q ^ t_vec;
            // Set wins over clear when both happen on one edge.
            if (tc) begin
                wrap <= 1'b1;
            end else if (clr_wrap) begin
                wrap <= 1'b0;
            end
        end
    end

endmodule
